// File: rtl/alu_md_if.sv
// Request/response bundle for the multi-cycle multiply/divide unit.
// The master side issues M-extension instructions; the slave side is the unit itself.
interface alu_md_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     inst;
  logic [XLEN-1:0] in1;
  logic [XLEN-1:0] in2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out;
  logic            out_illegal;

  modport master (
    output in_valid, inst, in1, in2, out_ready,
    input  in_ready, out_valid, out, out_illegal
  );

  modport slave (
    input  in_valid, inst, in1, in2, out_ready,
    output in_ready, out_valid, out, out_illegal
  );
endinterface

// File: rtl/alu_md.sv
// Multi-cycle RV M-extension unit: shift-add multiply / restoring divide, one bit per cycle,
// with optional single-cycle completion of trivial cases and flush/abort.
module alu_md #(
  parameter int XLEN      = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      flush,
  alu_md_if.slave   bus
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] acc_hi, acc_lo, b_reg;
  logic [2:0]      f3;
  logic            neg, special;
  logic [XLEN-1:0] out_q;
  logic            ill_q;

  // Decode of the offered instruction.
  logic [2:0]      funct3;
  logic            legal, is_div, a_signed, b_signed, sa, sb;
  logic [XLEN-1:0] mag_a, mag_b, spec_val;
  logic            div_zero, div_ovf, mul_zero, spec_hit, neg_in, accept;
  logic            unused_inst;

  assign funct3      = bus.inst[14:12];
  assign unused_inst = ^{bus.inst[24:15], bus.inst[11:7]};
  assign legal       = (bus.inst[6:0] == 7'b0110011) && (bus.inst[31:25] == 7'b0000001);
  assign is_div      = funct3[2];
  assign a_signed    = is_div ? ~funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
  assign b_signed    = is_div ? ~funct3[0] : (funct3[1:0] == 2'b01);
  assign sa          = a_signed & bus.in1[XLEN-1];
  assign sb          = b_signed & bus.in2[XLEN-1];
  assign mag_a       = sa ? -bus.in1 : bus.in1;
  assign mag_b       = sb ? -bus.in2 : bus.in2;
  assign div_zero    = is_div && (bus.in2 == '0);
  assign div_ovf     = is_div && !funct3[0] && (bus.in1 == MIN_INT) && (bus.in2 == '1);
  assign mul_zero    = !is_div && ((bus.in1 == '0) || (bus.in2 == '0));
  assign spec_hit    = div_zero || div_ovf || mul_zero;
  // Remainder takes the dividend's sign; quotient and products take the XOR.
  assign neg_in      = (is_div && funct3[1]) ? sa : (sa ^ sb);
  assign accept      = bus.in_valid && (state == IDLE) && !flush;

  always_comb begin
    spec_val = '0;
    if (div_zero)     spec_val = funct3[1] ? bus.in1 : '1;
    else if (div_ovf) spec_val = funct3[1] ? '0 : bus.in1;
  end

  // Iteration datapath.
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, result;

  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_reg} : '0);
  assign div_shift = {acc_hi, acc_lo[XLEN-1]};
  assign div_ge    = div_shift >= {1'b0, b_reg};
  assign div_diff  = div_shift - {1'b0, b_reg};
  assign prod_fix  = neg ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
  assign quo_fix   = neg ? -acc_lo : acc_lo;
  assign rem_fix   = neg ? -acc_hi : acc_hi;

  always_comb begin
    result = '0;
    if (special) result = b_reg;
    else begin
      case (f3)
        3'b000:                 result = prod_fix[XLEN-1:0];
        3'b001, 3'b010, 3'b011: result = prod_fix[2*XLEN-1:XLEN];
        3'b100, 3'b101:         result = quo_fix;
        default:                result = rem_fix;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) begin
        if (!legal)                     state_nx = DONE;
        else if (spec_hit && EARLY_OUT) state_nx = DONE;
        else                            state_nx = CALC;
      end
      CALC: if (cnt == '0) state_nx = FIX;
      FIX:  state_nx = DONE;
      DONE: if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  // NOTE: every register here is updated with <= so all of them see pre-edge values,
  // and every one is reset since there is no memory array to leave uninitialised.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      b_reg   <= '0;
      f3      <= '0;
      neg     <= 1'b0;
      special <= 1'b0;
      out_q   <= '0;
      ill_q   <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (accept) begin
          f3      <= funct3;
          neg     <= neg_in;
          special <= spec_hit;
          acc_hi  <= '0;
          acc_lo  <= mag_a;
          // A special case parks its answer in the divisor slot; the loop output is ignored.
          b_reg   <= spec_hit ? spec_val : mag_b;
          cnt     <= CW'(XLEN - 1);
          if (!legal) begin
            out_q <= '0;
            ill_q <= 1'b1;
          end else if (spec_hit && EARLY_OUT) begin
            out_q <= spec_val;
            ill_q <= 1'b0;
          end
        end
        CALC: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          if (f3[2]) begin
            acc_hi <= div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
            acc_lo <= {acc_lo[XLEN-2:0], div_ge};
          end else begin
            acc_hi <= mul_sum[XLEN:1];
            acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
          end
        end
        FIX: begin
          out_q <= result;
          ill_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready    = (state == IDLE);
  assign bus.out_valid   = (state == DONE);
  assign bus.out         = out_q;
  assign bus.out_illegal = ill_q;
endmodule

// File: tb/tb_alu_md.sv
// Self-checking bench for alu_md: directed vector table, corner sequences, and randomized
// operations scored against a plain-arithmetic reference, on both EARLY_OUT settings.
module tb_alu_md;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  logic        sel = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] inst = '0, in1 = '0, in2 = '0;

  alu_md_if #(.XLEN(32)) bus0 ();
  alu_md_if #(.XLEN(32)) bus1 ();

  alu_md #(.XLEN(32), .EARLY_OUT(1'b1)) dut0 (.clk(clk), .rst(rst), .flush(flush), .bus(bus0.slave));
  alu_md #(.XLEN(32), .EARLY_OUT(1'b0)) dut1 (.clk(clk), .rst(rst), .flush(flush), .bus(bus1.slave));

  assign bus0.in_valid  = in_valid & ~sel;
  assign bus1.in_valid  = in_valid & sel;
  assign bus0.inst      = inst;
  assign bus1.inst      = inst;
  assign bus0.in1       = in1;
  assign bus1.in1       = in1;
  assign bus0.in2       = in2;
  assign bus1.in2       = in2;
  assign bus0.out_ready = out_ready;
  assign bus1.out_ready = out_ready;

  logic        ordy, ovalid, oill;
  logic [31:0] oval;
  assign ordy   = sel ? bus1.in_ready    : bus0.in_ready;
  assign ovalid = sel ? bus1.out_valid   : bus0.out_valid;
  assign oval   = sel ? bus1.out         : bus0.out;
  assign oill   = sel ? bus1.out_illegal : bus0.out_illegal;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_inst(input logic [2:0] f3, input logic [6:0] f7, input logic [6:0] opc);
    return {f7, 5'd2, 5'd1, f3, 5'd3, opc};
  endfunction

  // Reference: RISC-V M semantics straight from 64-bit arithmetic and SV signed division.
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int sa, sb;
    sa = a;
    sb = b;
    case (f3)
      3'd0: begin p = {32'b0, a} * {32'b0, b};                 return p[31:0];  end
      3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b};     return p[63:32]; end
      3'd2: begin p = {{32{a[31]}}, a} * {32'b0, b};           return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b};                 return p[63:32]; end
      3'd4: if (b == 0) return '1; else if (a == 32'h80000000 && b == '1) return a; else return sa / sb;
      3'd5: if (b == 0) return '1; else return a / b;
      3'd6: if (b == 0) return a;  else if (a == 32'h80000000 && b == '1) return 0; else return sa % sb;
      default: if (b == 0) return a; else return a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic early);
    logic trivial;
    if (f3[2]) trivial = (b == 0) || (!f3[0] && a == 32'h80000000 && b == '1);
    else       trivial = (a == 0) || (b == 0);
    return (early && trivial) ? 1 : 34;
  endfunction

  // Issue one op, wait (bounded) for the result, hand it off; lat counts edges from accept.
  task automatic run_op(input logic [31:0] i_inst, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic ill, output int lat);
    @(negedge clk);
    inst = i_inst; in1 = a; in2 = b; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!ovalid && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    res = oval;
    ill = oill;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      default: return $urandom;
    endcase
  endfunction

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, v0;
    logic        il;
    int          lat, bad;
    logic [2:0]  f3;
    logic [31:0] a, b;

    vecs.push_back('{"mul_7_m3",     3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34});
    vecs.push_back('{"mulh_min_min", 3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 34});
    vecs.push_back('{"mulhsu_ff_ff", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34});
    vecs.push_back('{"mulhu_ff_ff",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34});
    vecs.push_back('{"div_m7_2",     3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34});
    vecs.push_back('{"rem_m7_2",     3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34});
    vecs.push_back('{"divu_ff_2",    3'd5, 32'hFFFFFFFF, 32'd2,        32'h7FFFFFFF, 34});
    vecs.push_back('{"remu_100_7",   3'd7, 32'd100,      32'd7,        32'd2,        34});
    vecs.push_back('{"div_5_0",      3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 1});
    vecs.push_back('{"rem_5_0",      3'd6, 32'd5,        32'd0,        32'd5,        1});
    vecs.push_back('{"divu_9_0",     3'd5, 32'd9,        32'd0,        32'hFFFFFFFF, 1});
    vecs.push_back('{"remu_9_0",     3'd7, 32'd9,        32'd0,        32'd9,        1});
    vecs.push_back('{"div_ovf",      3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
    vecs.push_back('{"rem_ovf",      3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1});
    vecs.push_back('{"mul_0_5",      3'd0, 32'd0,        32'd5,        32'd0,        1});
    vecs.push_back('{"mulhu_5_0",    3'd3, 32'd5,        32'd0,        32'd0,        1});

    // Reset values.
    #12;
    check("rst_in_ready", ordy, 1);
    check("rst_out_valid", ovalid, 0);
    check("rst_out", oval, 0);
    check("rst_out_illegal", oill, 0);
    @(negedge clk);
    rst = 1'b1;

    // Directed table on both builds; the full-latency build never finishes early.
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      foreach (vecs[k]) begin
        run_op(mk_inst(vecs[k].f3, 7'b0000001, 7'b0110011), vecs[k].a, vecs[k].b, r, il, lat);
        check($sformatf("%s_eo%0d_out", vecs[k].name, 1 - s), r, vecs[k].exp);
        check($sformatf("%s_eo%0d_ill", vecs[k].name, 1 - s), il, 0);
        check($sformatf("%s_eo%0d_lat", vecs[k].name, 1 - s), lat, (s == 0) ? vecs[k].lat : 34);
      end
    end
    sel = 1'b0;

    // Randomized ops against the reference on both builds.
    for (int n = 0; n < 200; n++) begin
      sel = n[0];
      f3 = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      run_op(mk_inst(f3, 7'b0000001, 7'b0110011), a, b, r, il, lat);
      check($sformatf("rnd%0d_f%0d_%h_%h_out", n, f3, a, b), r, ref_result(f3, a, b));
      check($sformatf("rnd%0d_lat", n), lat, ref_lat(f3, a, b, !sel));
    end
    sel = 1'b0;

    // Backpressure: result held, no accept while DONE even with a new request pending.
    @(negedge clk);
    inst = mk_inst(3'd5, 7'b0000001, 7'b0110011); in1 = 32'd1000; in2 = 32'd3; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in1 = 32'd77;
    lat = 1;
    while (!ovalid && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    v0 = oval;
    check("bp_first_out", v0, 333);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (oval !== v0 || ordy !== 1'b0 || ovalid !== 1'b1) bad++;
    end
    check("bp_hold_bad_cycles", bad, 0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_ready", ordy, 1);
    check("bp_release_valid", ovalid, 0);

    // Flush at cycle 5 of a DIVU.
    @(negedge clk);
    inst = mk_inst(3'd5, 7'b0000001, 7'b0110011); in1 = 32'd1000; in2 = 32'd7; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    check("flush_in_ready", ordy, 1);
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      if (ovalid) bad++;
      @(negedge clk);
    end
    check("flush_no_result", bad, 0);
    run_op(mk_inst(3'd0, 7'b0000001, 7'b0110011), 32'd3, 32'd4, r, il, lat);
    check("after_flush_mul", r, 12);
    check("after_flush_lat", lat, 34);

    // Flush together with in_valid in IDLE must not accept.
    @(negedge clk);
    inst = mk_inst(3'd0, 7'b0000001, 7'b0110011); in1 = 32'd3; in2 = 32'd4;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    check("flush_idle_no_accept", ordy, 1);

    // Flush in DONE beats a simultaneous handoff and drops the result.
    @(negedge clk);
    inst = mk_inst(3'd4, 7'b0000001, 7'b0110011); in1 = 32'd5; in2 = 32'd0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("flush_done_valid_before", ovalid, 1);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b0;
    check("flush_done_valid_after", ovalid, 0);
    check("flush_done_ready_after", ordy, 1);

    // Illegal encodings, then a legal op clears the flag.
    run_op(mk_inst(3'd0, 7'b0100000, 7'b0110011), 32'd9, 32'd4, r, il, lat);
    check("illegal_f7_ill", il, 1);
    check("illegal_f7_out", r, 0);
    check("illegal_f7_lat", lat, 1);
    run_op(mk_inst(3'd0, 7'b0000001, 7'b0010011), 32'd9, 32'd4, r, il, lat);
    check("illegal_opc_ill", il, 1);
    check("illegal_opc_lat", lat, 1);
    run_op(mk_inst(3'd0, 7'b0000001, 7'b0110011), 32'd9, 32'd4, r, il, lat);
    check("legal_after_illegal_ill", il, 0);
    check("legal_after_illegal_out", r, 36);

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    inst = mk_inst(3'd1, 7'b0000001, 7'b0110011); in1 = 32'd11; in2 = 32'd13; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst_in_ready", ordy, 1);
    check("async_rst_out_valid", ovalid, 0);
    check("async_rst_out", oval, 0);
    check("async_rst_out_illegal", oill, 0);
    @(negedge clk);
    rst = 1'b1;
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ovalid) bad++;
    end
    check("async_rst_no_result", bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
